// File: rtl/tl_coupler_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tl_coupler_arbiter
// Purpose  : Two-requester TileLink-UL arbiter in front of a fragmenter
//            coupler. A-channel messages are arbitrated round-robin, with
//            the grant locked for the whole of a multi-beat message. A per-
//            requester outstanding counter throttles requesters that have too
//            many unacknowledged messages. D-channel beats are routed back by
//            the top bit of the returned source field.
// Ports    : clock, reset_n          - clock, synchronous active-low reset
//            in0_a_* / in1_a_*       - requester A channels (into arbiter)
//            in0_d_* / in1_d_*       - requester D channels (out of arbiter)
//            out_a_*                 - merged A channel toward the coupler
//            out_d_*                 - D channel from the coupler
//            outstanding0/1          - unacknowledged message counts
//            err_underflow           - sticky: D last beat with count at 0
// Revision : 1.0 - initial release
// ============================================================================
module tl_coupler_arbiter #(
    parameter int MAX_OUTSTANDING = 8,
    parameter int DATA_BYTES      = 8
) (
    input  logic                      clock,
    input  logic                      reset_n,
    // requester 0 A channel
    input  logic                      in0_a_valid,
    output logic                      in0_a_ready,
    input  logic [2:0]                in0_a_opcode,
    input  logic [2:0]                in0_a_param,
    input  logic [2:0]                in0_a_size,
    input  logic [5:0]                in0_a_source,
    input  logic [11:0]               in0_a_address,
    input  logic [DATA_BYTES-1:0]     in0_a_mask,
    input  logic [DATA_BYTES*8-1:0]   in0_a_data,
    input  logic                      in0_a_corrupt,
    // requester 1 A channel
    input  logic                      in1_a_valid,
    output logic                      in1_a_ready,
    input  logic [2:0]                in1_a_opcode,
    input  logic [2:0]                in1_a_param,
    input  logic [2:0]                in1_a_size,
    input  logic [5:0]                in1_a_source,
    input  logic [11:0]               in1_a_address,
    input  logic [DATA_BYTES-1:0]     in1_a_mask,
    input  logic [DATA_BYTES*8-1:0]   in1_a_data,
    input  logic                      in1_a_corrupt,
    // requester 0 D channel
    input  logic                      in0_d_ready,
    output logic                      in0_d_valid,
    output logic [2:0]                in0_d_opcode,
    output logic [2:0]                in0_d_size,
    output logic [5:0]                in0_d_source,
    output logic [DATA_BYTES*8-1:0]   in0_d_data,
    // requester 1 D channel
    input  logic                      in1_d_ready,
    output logic                      in1_d_valid,
    output logic [2:0]                in1_d_opcode,
    output logic [2:0]                in1_d_size,
    output logic [5:0]                in1_d_source,
    output logic [DATA_BYTES*8-1:0]   in1_d_data,
    // merged A channel toward the coupler
    output logic                      out_a_valid,
    input  logic                      out_a_ready,
    output logic [2:0]                out_a_opcode,
    output logic [2:0]                out_a_param,
    output logic [2:0]                out_a_size,
    output logic [6:0]                out_a_source,
    output logic [11:0]               out_a_address,
    output logic [DATA_BYTES-1:0]     out_a_mask,
    output logic [DATA_BYTES*8-1:0]   out_a_data,
    output logic                      out_a_corrupt,
    // D channel from the coupler
    input  logic                      out_d_valid,
    output logic                      out_d_ready,
    input  logic [2:0]                out_d_opcode,
    input  logic [2:0]                out_d_size,
    input  logic [6:0]                out_d_source,
    input  logic [DATA_BYTES*8-1:0]   out_d_data,
    // status
    output logic [3:0]                outstanding0,
    output logic [3:0]                outstanding1,
    output logic                      err_underflow
);

    localparam logic [3:0] c_max_outst = 4'(MAX_OUTSTANDING);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_a_cnt;
    logic [4:0]  w_a_cnt_nxt;
    logic        r_lock;
    logic        r_ptr;
    logic [4:0]  r_d_cnt;
    logic [3:0]  r_outst0;
    logic [3:0]  r_outst1;
    logic        r_err;

    logic        w_elig0;
    logic        w_elig1;
    logic        w_cand0;
    logic        w_cand1;
    logic        w_grant;
    logic        w_a_valid_raw;
    logic        w_a_fire;
    logic        w_a_first;
    logic [4:0]  w_a_beats;
    logic        w_d_dst;
    logic        w_d_fire;
    logic        w_d_last;
    logic [4:0]  w_d_beats;
    logic [4:0]  w_outst0_nxt;
    logic [4:0]  w_outst1_nxt;

    // Beats in an A message: only Put/Arithmetic/Logical opcodes carry data.
    function automatic logic [4:0] a_beats(input logic [2:0] op, input logic [2:0] size);
        if (op <= 3'd3 && size > 3'd3) begin
            return 5'd1 << (size - 3'd3);
        end
        return 5'd1;
    endfunction

    // Beats in a D message: only AccessAckData carries data.
    function automatic logic [4:0] d_beats(input logic [2:0] op, input logic [2:0] size);
        if (op == 3'd1 && size > 3'd3) begin
            return 5'd1 << (size - 3'd3);
        end
        return 5'd1;
    endfunction

    // Returns {underflow, next_count}; a coincident +1/-1 cancels out.
    function automatic logic [4:0] outst_next(input logic [3:0] cur, input logic inc,
                                              input logic dec);
        case ({inc, dec})
            2'b10:   return {1'b0, cur + 4'd1};
            2'b01:   return (cur == 4'd0) ? 5'b1_0000 : {1'b0, cur - 4'd1};
            default: return {1'b0, cur};
        endcase
    endfunction

    // ------------------------------------------------------------------
    // A channel arbitration
    // ------------------------------------------------------------------
    assign w_elig0 = (r_outst0 < c_max_outst);
    assign w_elig1 = (r_outst1 < c_max_outst);
    assign w_cand0 = in0_a_valid & w_elig0;
    assign w_cand1 = in1_a_valid & w_elig1;

    // A lone candidate wins outright; otherwise the pointer decides.
    always_comb begin
        w_grant = r_ptr;
        if (r_state == LOCKED) begin
            w_grant = r_lock;
        end else if (w_cand0 ^ w_cand1) begin
            w_grant = w_cand1;
        end
    end

    assign w_a_valid_raw = (r_state == LOCKED) ? (r_lock ? in1_a_valid : in0_a_valid)
                                               : (w_cand0 | w_cand1);

    assign out_a_valid   = reset_n & w_a_valid_raw;
    assign in0_a_ready   = reset_n & out_a_ready & ~w_grant
                         & (w_elig0 | ((r_state == LOCKED) & ~r_lock));
    assign in1_a_ready   = reset_n & out_a_ready &  w_grant
                         & (w_elig1 | ((r_state == LOCKED) &  r_lock));

    assign out_a_opcode  = w_grant ? in1_a_opcode  : in0_a_opcode;
    assign out_a_param   = w_grant ? in1_a_param   : in0_a_param;
    assign out_a_size    = w_grant ? in1_a_size    : in0_a_size;
    assign out_a_source  = {w_grant, (w_grant ? in1_a_source : in0_a_source)};
    assign out_a_address = w_grant ? in1_a_address : in0_a_address;
    assign out_a_mask    = w_grant ? in1_a_mask    : in0_a_mask;
    assign out_a_data    = w_grant ? in1_a_data    : in0_a_data;
    assign out_a_corrupt = w_grant ? in1_a_corrupt : in0_a_corrupt;

    assign w_a_fire  = out_a_valid & out_a_ready;
    assign w_a_first = w_a_fire & (r_state == IDLE);
    assign w_a_beats = a_beats(out_a_opcode, out_a_size);

    // Grant FSM: r_a_cnt holds the beats still to come in a locked message.
    always_comb begin
        w_state_nxt = r_state;
        w_a_cnt_nxt = r_a_cnt;
        case (r_state)
            IDLE: begin
                if (w_a_first && (w_a_beats != 5'd1)) begin
                    w_state_nxt = LOCKED;
                    w_a_cnt_nxt = w_a_beats - 5'd1;
                end
            end
            LOCKED: begin
                if (w_a_fire) begin
                    if (r_a_cnt == 5'd1) begin
                        w_state_nxt = IDLE;
                        w_a_cnt_nxt = 5'd0;
                    end else begin
                        w_a_cnt_nxt = r_a_cnt - 5'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_a_cnt_nxt = 5'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // D channel routing
    // ------------------------------------------------------------------
    assign w_d_dst      = out_d_source[6];
    assign out_d_ready  = reset_n & (w_d_dst ? in1_d_ready : in0_d_ready);
    assign in0_d_valid  = reset_n & out_d_valid & ~w_d_dst;
    assign in1_d_valid  = reset_n & out_d_valid &  w_d_dst;
    assign in0_d_opcode = out_d_opcode;
    assign in0_d_size   = out_d_size;
    assign in0_d_source = out_d_source[5:0];
    assign in0_d_data   = out_d_data;
    assign in1_d_opcode = out_d_opcode;
    assign in1_d_size   = out_d_size;
    assign in1_d_source = out_d_source[5:0];
    assign in1_d_data   = out_d_data;

    // r_d_cnt == 0 means the next beat starts a new D message.
    assign w_d_fire  = out_d_valid & out_d_ready;
    assign w_d_beats = d_beats(out_d_opcode, out_d_size);
    assign w_d_last  = w_d_fire & ((r_d_cnt == 5'd0) ? (w_d_beats == 5'd1) : (r_d_cnt == 5'd1));

    assign w_outst0_nxt = outst_next(r_outst0, w_a_first & ~w_grant, w_d_last & ~w_d_dst);
    assign w_outst1_nxt = outst_next(r_outst1, w_a_first &  w_grant, w_d_last &  w_d_dst);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_a_cnt  <= 5'd0;
            r_lock   <= 1'b0;
            r_ptr    <= 1'b0;
            r_d_cnt  <= 5'd0;
            r_outst0 <= 4'd0;
            r_outst1 <= 4'd0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_a_cnt <= w_a_cnt_nxt;
            if (w_a_first) begin
                r_lock <= w_grant;
                r_ptr  <= ~w_grant;
            end
            if (w_d_fire) begin
                r_d_cnt <= (r_d_cnt == 5'd0) ? (w_d_beats - 5'd1) : (r_d_cnt - 5'd1);
            end
            r_outst0 <= w_outst0_nxt[3:0];
            r_outst1 <= w_outst1_nxt[3:0];
            r_err    <= r_err | w_outst0_nxt[4] | w_outst1_nxt[4];
        end
    end

    assign outstanding0  = r_outst0;
    assign outstanding1  = r_outst1;
    assign err_underflow = r_err;

endmodule
`default_nettype wire

// File: doc/tl_coupler_arbiter.md
TL_COUPLER_ARBITER -- requirements
Module: tl_coupler_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 8, meaning the maximum number of unacknowledged requests per requester (range 1..15).
REQ-002 SHALL have parameter DATA_BYTES, default 8, meaning the beat width in bytes (fixed at 8; no other value is supported).
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have, for N in {0,1}, the A-channel ports of requester N:
- inN_a_valid, input, 1
- inN_a_ready, output, 1
- inN_a_opcode / param / size, input, 3 each
- inN_a_source, input, 6
- inN_a_address, input, 12
- inN_a_mask, input, 8
- inN_a_data, input, 64
- inN_a_corrupt, input, 1
REQ-006 SHALL have, for N in {0,1}, the D-channel ports of requester N:
- inN_d_ready, input, 1
- inN_d_valid, output, 1
- inN_d_opcode / size, output, 3 each
- inN_d_source, output, 6
- inN_d_data, output, 64
REQ-007 SHALL have out_a_* ports toward the fragmenter coupler: the same fields as REQ-005 with directions reversed and a 7-bit source; out_a_ready is an input.
REQ-008 SHALL have out_d_* ports from the coupler: valid, opcode, size and data as inputs, source as a 7-bit input, and ready as an output.

Function
REQ-009 SHALL forward the granted requester's A fields combinationally to out_a_*, with zero latency.
REQ-010 SHALL drive out_a_source as {grant_index, inN_a_source}.
REQ-011 SHALL give each A message a beat count as follows:
- data-bearing opcodes (0, 1, 2, 3) with size > 3: 2^(size-3) beats
- all other cases: 1 beat
REQ-012 SHALL hold grant state in a two-state FSM, IDLE and LOCKED:
- IDLE: arbitrate combinationally among eligible valid requesters.
- IDLE to LOCKED: a first beat fires and the message has more than 1 beat; load the beat counter with beats-1.
- LOCKED: keep the grant fixed and decrement the counter on each fire.
- LOCKED to IDLE: the last beat fires (counter is 1).
REQ-013 SHALL arbitrate round-robin:
- A priority pointer names the preferred requester.
- On each first-beat fire, the pointer moves to the requester that was not granted.
- When exactly one eligible requester is valid, that requester is granted regardless of the pointer.
REQ-014 SHALL treat requester N as eligible only when outstanding[N] < MAX_OUTSTANDING; in LOCKED state the locked requester stays granted regardless of eligibility.
REQ-015 SHALL drive inN_a_ready = out_a_ready AND (grant == N) AND (requester N eligible or LOCKED on N).
REQ-016 SHALL route D beats by out_d_source[6]:
- inN_d_valid = out_d_valid AND (out_d_source[6] == N)
- out_d_ready = the ready input of the addressed requester
- inN_d_source = out_d_source[5:0]
- the remaining D fields pass through unchanged
REQ-017 SHALL count D beats:
- opcode 1 (AccessAckData) with size > 3 lasts 2^(size-3) beats; all other D messages last 1 beat.
- A D beat counter tracks the current message; D messages never interleave.
REQ-018 SHALL update outstanding[N] (4 bits) as follows:
- +1 on each first-beat A fire from N
- -1 on each last-beat D fire to N
- unchanged when both occur in the same cycle
REQ-019 SHALL never let outstanding[N] wrap; a D last beat while outstanding[N] is 0 leaves it at 0 and asserts the sticky output err_underflow (1 bit).
REQ-020 SHALL report outstanding counts on outputs outstanding0 and outstanding1 (4 bits each).

Reset
REQ-021 SHALL, while reset_n is 0 at a clock edge, set the FSM to IDLE, the beat counters to 0, the priority pointer to requester 0, both outstanding counts to 0, and err_underflow to 0.
REQ-022 SHALL force out_a_valid, in0_a_ready, in1_a_ready, in0_d_valid, in1_d_valid and out_d_ready to 0 while reset_n is 0, including a reset asserted mid-message; the message in flight is abandoned.

Verification
REQ-023 SHALL cover contention:
- Stimulus: both requesters present 1-beat Gets continuously after reset, out_a_ready = 1.
- Response: grants alternate 0, 1, 0, 1; out_a_source[6] toggles each cycle.
REQ-024 SHALL cover burst lock:
- Stimulus: in0 sends PutFull size 6 (8 beats) while in1 is valid.
- Response: in1_a_ready = 0 for all 8 beats, and in1 is granted in the cycle after the last beat.
REQ-025 SHALL cover the outstanding limit:
- Stimulus: with MAX_OUTSTANDING = 2, in0 issues 3 Gets and no D traffic.
- Response: after 2 fires, in0_a_ready = 0 and outstanding0 = 2; one AccessAck to source 0x05 brings outstanding0 to 1 and in0 is granted again.
REQ-026 SHALL cover D routing:
- Stimulus: out_d AccessAckData size 6, source 0x45.
- Response: 8 beats appear on in1_d with source 0x05; in0_d_valid stays 0; outstanding1 decrements once, on the 8th beat.
REQ-027 SHALL cover a simultaneous event:
- Stimulus: an A first-beat fire and a D last-beat fire for in0 in the same cycle.
- Response: outstanding0 is unchanged.
REQ-028 SHALL cover reset mid-operation:
- Stimulus: reset_n is driven to 0 during beat 3 of an 8-beat Put.
- Response: the next cycle shows IDLE state, all counts 0, and the pointer on requester 0.
